dist_ram_dp_cfg: RTL and testbench

Next-generation simple dual-port distributed RAM: one write port, one read port, single clock. It adds the following over the current RAM:
- Per-byte write enables.
- Selectable read latency: asynchronous, or one registered stage.
- Selectable read-during-write collision mode.
- A read-valid flag.
- A post-reset hardware clear sequencer that zeroes every location.

It serves as the storage element for FIFOs, small lookup tables and register files.

---
 rtl/dist_ram_pkg.sv | 26 ++
 rtl/dist_ram_core.sv | 36 +++
 rtl/dist_ram_dp_cfg.sv | 138 +++++++++++++
 tb/tb_dist_ram_dp_cfg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dist_ram_pkg.sv
// Shared types and helpers for the configurable
// dual-port distributed RAM.
package dist_ram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } coll_mode_e;

  typedef enum logic {
    CLEAR,
    READY
  } clr_state_e;

  localparam int MRG_W = 1024;

  // Take nw where msk is set, od elsewhere
  function automatic logic [MRG_W-1:0] be_merge(
    input logic [MRG_W-1:0] nw,
    input logic [MRG_W-1:0] od,
    input logic [MRG_W-1:0] msk
  );
    return (nw & msk) | (od & ~msk);
  endfunction

endpackage

// File: rtl/dist_ram_core.sv
// Bare distributed array: byte-enabled
// synchronous write, asynchronous read.
module dist_ram_core #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  (* ram_style = "distributed" *)
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Lane-masked write into the array
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (i_be[k]) begin
          r_mem[i_addr][k*BYTE_W +: BYTE_W] <=
            i_wdata[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dist_ram_dp_cfg.sv
// Simple dual-port distributed RAM with byte
// enables, read latency/collision options, clear.
module dist_ram_dp_cfg
  import dist_ram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BYTE_W     = 8,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 1,
  parameter int COLL_MODE  = 0,
  parameter int CLR_ON_RST = 1,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int BE_W       = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_ramen,
  input  logic              i_wren,
  input  logic [BE_W-1:0]   i_wbe,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rden,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_busy
);

  localparam coll_mode_e CM =
    coll_mode_e'(COLL_MODE[0]);
  localparam logic [ADDR_W:0] DEPTH_V =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(DEPTH-1);
  localparam clr_state_e RST_ST =
    (CLR_ON_RST != 0) ? CLEAR : READY;

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;

  logic              w_busy;
  logic              w_wa_in;
  logic              w_ra_in;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_coll;
  logic [DATA_W-1:0] w_bmask;
  logic              w_c_we;
  logic [ADDR_W-1:0] w_c_addr;
  logic [BE_W-1:0]   w_c_be;
  logic [DATA_W-1:0] w_c_wd;
  logic [DATA_W-1:0] w_c_rd;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_new;
  logic [DATA_W-1:0] w_rd_word;

  // Clear sequencer: zero one word per cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RST_ST;
      r_cnt   <= '0;
    end else if (r_state == CLEAR) begin
      if (r_cnt == LAST_A) r_state <= READY;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_busy  = (r_state == CLEAR);
  assign o_busy  = w_busy;

  assign w_wa_in = ({1'b0, i_waddr} < DEPTH_V);
  assign w_ra_in = ({1'b0, i_raddr} < DEPTH_V);

  assign w_wr_acc = rstn & i_ramen & i_wren
                  & ~w_busy & w_wa_in;
  assign w_rd_acc = rstn & i_ramen & i_rden
                  & ~w_busy;

  for (genvar k = 0; k < BE_W; k++) begin : g_msk
    assign w_bmask[k*BYTE_W +: BYTE_W] =
      {BYTE_W{i_wbe[k]}};
  end

  assign w_c_we   = w_busy | w_wr_acc;
  assign w_c_addr = w_busy ? r_cnt : i_waddr;
  assign w_c_be   = w_busy ? {BE_W{1'b1}} : i_wbe;
  assign w_c_wd   = w_busy ? '0 : i_wdata;

  dist_ram_core #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_c_we),
    .i_be    (w_c_be),
    .i_addr  (w_c_addr),
    .i_wdata (w_c_wd),
    .i_raddr (i_raddr),
    .o_rdata (w_c_rd)
  );

  assign w_old  = w_ra_in ? w_c_rd : '0;
  assign w_coll = w_rd_acc & w_wr_acc
                & (i_waddr == i_raddr);
  assign w_new  = DATA_W'(be_merge(
                    MRG_W'(i_wdata),
                    MRG_W'(w_old),
                    MRG_W'(w_bmask)));

  assign w_rd_word =
    (w_coll && CM == WRITE_FIRST) ? w_new : w_old;

  if (RD_LAT == 0) begin : g_async
    assign o_rdata  = w_rd_acc ? w_rd_word : '0;
    assign o_rvalid = w_rd_acc;
  end else begin : g_reg
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    // Output stage; data holds between reads
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd_acc;
        if (w_rd_acc) r_rdata <= w_rd_word;
      end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
  end

endmodule

// File: tb/tb_dist_ram_dp_cfg.sv
// Scoreboard bench: A = 16 deep, registered,
// write-first; B = 12 deep, async, read-first.
module tb_dist_ram_dp_cfg;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ramen = 1'b0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [3:0]  wbe = '0;
  logic [3:0]  waddr = '0;
  logic [3:0]  raddr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid;
  logic        a_busy, b_busy;

  always #5 clk = ~clk;

  dist_ram_dp_cfg #(
    .DEPTH(16), .RD_LAT(1),
    .COLL_MODE(0), .CLR_ON_RST(1)
  ) u_a (
    .clk(clk), .rstn(rstn),
    .i_ramen(ramen), .i_wren(wren),
    .i_wbe(wbe), .i_waddr(waddr),
    .i_wdata(wdata), .i_rden(rden),
    .i_raddr(raddr), .o_rdata(a_rdata),
    .o_rvalid(a_rvalid), .o_busy(a_busy)
  );

  dist_ram_dp_cfg #(
    .DEPTH(12), .RD_LAT(0),
    .COLL_MODE(1), .CLR_ON_RST(1)
  ) u_b (
    .clk(clk), .rstn(rstn),
    .i_ramen(ramen), .i_wren(wren),
    .i_wbe(wbe), .i_waddr(waddr),
    .i_wdata(wdata), .i_rden(rden),
    .i_raddr(raddr), .o_rdata(b_rdata),
    .o_rvalid(b_rvalid), .o_busy(b_busy)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } exp_t;

  int          n_vec = 0;
  int          n_mis = 0;
  int          cyc = 0;
  logic [31:0] last_a = '0;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  exp_t        q_a [$];
  exp_t        q_b [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mrg(
    input logic [31:0] n,
    input logic [31:0] o,
    input logic [3:0]  be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
    return r;
  endfunction

  // Called at a negedge; returns at the next one
  task automatic step(
    input logic        en,
    input logic        we,
    input logic [3:0]  be,
    input logic [3:0]  wa,
    input logic [31:0] wd,
    input logic        re,
    input logic [3:0]  ra);
    logic        ba, bb;
    logic        wacc_a, wacc_b;
    logic        racc_a, racc_b;
    logic [31:0] ea;
    exp_t        e;
    ramen = en; wren = we; wbe = be;
    waddr = wa; wdata = wd;
    rden = re; raddr = ra;
    #1;
    ba = (cyc < 16);
    bb = (cyc < 12);
    chk("busy_a", a_busy, ba);
    chk("busy_b", b_busy, bb);
    wacc_a = en & we & ~ba;
    wacc_b = en & we & ~bb & (wa < 12);
    racc_a = en & re & ~ba;
    racc_b = en & re & ~bb;
    ea = mem_a[ra];
    if (wacc_a && wa == ra) ea = mrg(wd, ea, be);
    if (racc_a) last_a = ea;
    e.v = racc_a;
    e.d = last_a;
    q_a.push_back(e);
    e.v = racc_b;
    e.d = (ra < 12) ? mem_b[ra] : 32'h0;
    q_b.push_back(e);
    e = q_b.pop_front();
    chk("rvalid_b", b_rvalid, e.v);
    if (e.v) chk("rdata_b", b_rdata, e.d);
    if (wacc_a) mem_a[wa] = mrg(wd, mem_a[wa], be);
    if (wacc_b) mem_b[wa] = mrg(wd, mem_b[wa], be);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (q_a.size() == 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL q_a got empty exp entry");
    end else begin
      e = q_a.pop_front();
      chk("rvalid_a", a_rvalid, e.v);
      chk("rdata_a", a_rdata, e.d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1, 0, 4'h0, 4'h0, 32'h0, 1, a);
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be);
    step(1, 1, be, a, d, 0, 4'h0);
  endtask

  task automatic do_reset();
    ramen = 0; wren = 0; rden = 0;
    rstn = 1'b0;
    #1;
    chk("rst_rdata_a", a_rdata, 32'h0);
    chk("rst_rvalid_a", a_rvalid, 1'b0);
    chk("rst_busy_a", a_busy, 1'b1);
    chk("rst_busy_b", b_busy, 1'b1);
    chk("rst_rvalid_b", b_rvalid, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
    last_a = '0;
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    // busy window, with a dropped write/read
    idle(3);
    step(1, 1, 4'hf, 4'h2, 32'h12345678, 1, 4'h2);
    idle(12);
    for (int i = 0; i < 16; i++) rd(4'(i));
    // byte lanes
    wr(4'h3, 32'hAABBCCDD, 4'b1111);
    wr(4'h3, 32'h11223344, 4'b0101);
    rd(4'h3);
    chk("be_merge_a", a_rdata, 32'hAA22CC44);
    wr(4'h4, 32'h55667788, 4'b0000);
    rd(4'h4);
    // collision on 5, then re-read
    step(1, 1, 4'b0011, 4'h5, 32'hDEADBEEF, 1, 4'h5);
    chk("coll_wf_a", a_rdata, 32'h0000BEEF);
    rd(4'h5);
    chk("after_coll_a", a_rdata, 32'h0000BEEF);
    // out of range for B
    wr(4'hD, 32'hFFFFFFFF, 4'hf);
    rd(4'hD);
    for (int i = 0; i < 12; i++) rd(4'(i));
    // disabled RAM: no write, output holds
    rd(4'h3);
    step(0, 1, 4'hf, 4'h3, 32'h0BADF00D, 1, 4'h3);
    step(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'h9);
    rd(4'h3);
    // random traffic
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 3) != 0,
           1'($urandom),
           4'($urandom),
           4'($urandom),
           $urandom,
           1'($urandom),
           4'($urandom));
    // reset mid-clear restarts the clear
    do_reset();
    idle(7);
    do_reset();
    idle(16);
    for (int i = 0; i < 16; i++) rd(4'(i));
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
